// File: rtl/switch_input_pkg.sv
// Shared constants for the switch/key input block: register map, status bit
// indices and the control register layout.
package switch_input_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned NUM_SW  = 64;
  localparam int unsigned NUM_KEY = 8;
  localparam int unsigned NUM_IN  = NUM_SW + NUM_KEY;
  localparam int unsigned STAT_W  = 2;

  localparam logic [ADDR_W-1:0] ADDR_SW_LO = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_SW_HI = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_KEY   = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_STAT  = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_CTRL  = 3'd4;

  localparam int unsigned STAT_SW_CHG    = 0;
  localparam int unsigned STAT_KEY_PRESS = 1;

  typedef struct packed {
    logic ie;
  } ctrl_t;

endpackage

// File: rtl/switch_input_debounce_bit.sv
// One input bit: 2-flop synchronizer, inversion to active-high, tick-sampled
// history and accept-on-uniform-history debounced output.
module debounce_bit
  import switch_input_pkg::*;
#(
  parameter int unsigned STABLE_SAMPLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic debounced
);

  logic [1:0]                sync;
  logic [STABLE_SAMPLES-1:0] hist;
  logic                      sample_c;

  assign sample_c = ~sync[1];

  // History only advances on the slow tick; the output moves only on a uniform history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync      <= '0;
      hist      <= '0;
      debounced <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (tick) begin
        hist <= STABLE_SAMPLES'({hist, sample_c});
      end
      if (&hist) begin
        debounced <= 1'b1;
      end else if (~|hist) begin
        debounced <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/switch_input.sv
// Debounced DIP switch / push key input block with a small register interface.
// Define SWITCH_IRQ_EN to enable the ctrl.ie register and the irq output.
module switch_input
  import switch_input_pkg::*;
#(
  parameter int unsigned TICK_WIDTH     = 16,
  parameter int unsigned STABLE_SAMPLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  input  logic [NUM_SW-1:0] dip_switch,
  input  logic [NUM_KEY-1:0] user_key,
  output logic              irq
);

  logic [TICK_WIDTH-1:0] tick_cnt;
  logic                  tick_c;
  logic [NUM_IN-1:0]     raw;
  logic [NUM_IN-1:0]     deb;
  logic [NUM_IN-1:0]     deb_prev;
  logic [NUM_SW-1:0]     sw;
  logic [NUM_SW-1:0]     sw_prev;
  logic [NUM_KEY-1:0]    keys;
  logic [NUM_KEY-1:0]    keys_prev;
  logic [STAT_W-1:0]     status;
  logic [STAT_W-1:0]     set_c;
  logic [STAT_W-1:0]     clr_c;
  ctrl_t                 ctrl;
  logic                  unused_din;

  assign unused_din = ^din[DATA_W-1:STAT_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_WIDTH'(1);
    end
  end

  // Tick fires on the edge where the counter wraps from all-ones to zero.
  assign tick_c = &tick_cnt;
  assign raw    = {user_key, dip_switch};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_bit
    debounce_bit #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_bit (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick_c),
      .raw      (raw[i]),
      .debounced(deb[i])
    );
  end

  assign sw        = deb[NUM_SW-1:0];
  assign keys      = deb[NUM_IN-1:NUM_SW];
  assign sw_prev   = deb_prev[NUM_SW-1:0];
  assign keys_prev = deb_prev[NUM_IN-1:NUM_SW];

  always_comb begin
    set_c                 = '0;
    clr_c                 = '0;
    set_c[STAT_SW_CHG]    = |(sw ^ sw_prev);
    set_c[STAT_KEY_PRESS] = |(keys & ~keys_prev);
    if (we && (addr == ADDR_STAT)) begin
      clr_c = din[STAT_W-1:0];
    end
  end

  // Sticky status: clear is applied first so a coincident set survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_prev <= '0;
      status   <= '0;
    end else begin
      deb_prev <= deb;
      status   <= (status & ~clr_c) | set_c;
    end
  end

`ifdef SWITCH_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl <= '0;
      irq  <= 1'b0;
    end else begin
      if (we && (addr == ADDR_CTRL)) begin
        ctrl.ie <= din[0];
      end
      irq <= ctrl.ie & (|status);
    end
  end
`else
  assign ctrl = '0;
  assign irq  = 1'b0;
`endif

  always_comb begin
    dout = '0;
    case (addr)
      ADDR_SW_LO: dout = sw[31:0];
      ADDR_SW_HI: dout = sw[63:32];
      ADDR_KEY:   dout = DATA_W'(keys);
      ADDR_STAT:  dout = DATA_W'(status);
      ADDR_CTRL:  dout = DATA_W'(ctrl.ie);
      default:    dout = '0;
    endcase
  end

endmodule

// File: tb/tb_switch_input.sv
// Bench for switch_input: directed scenarios plus random input/bus activity,
// checked every cycle against a tick-sample reference model.
module tb_switch_input;

  localparam int unsigned TW = 4;
  localparam int unsigned SS = 3;
  localparam int unsigned TP = 1 << TW;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [31:0] din = 32'd0;
  logic [31:0] dout;
  logic [63:0] dip_switch = '1;
  logic [7:0]  user_key = '1;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  always #10 clk = ~clk;

  switch_input #(
    .TICK_WIDTH    (TW),
    .STABLE_SAMPLES(SS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .addr      (addr),
    .din       (din),
    .dout      (dout),
    .dip_switch(dip_switch),
    .user_key  (user_key),
    .irq       (irq)
  );

  // Reference model: active-high view of the inputs, sampled every TP cycles
  // after a two-cycle delay; a bit is accepted once its last SS samples agree.
  int unsigned  n_m = 0;
  int unsigned  ticks_m = 0;
  logic [71:0]  raw_d1 = '0, raw_d2 = '0, deb_cur = '0, deb_prev = '0;
  logic [71:0]  smp[$];
  logic [1:0]   stat_m = '0;
  logic         ie_m = 1'b0, irq_m = 1'b0;

  always @(posedge clk or posedge reset) begin : model
    logic [71:0] raw_now, and_all, or_all, nxt;
    logic [1:0]  set, clr;
    if (reset) begin
      n_m = 0; raw_d1 = '0; raw_d2 = '0; deb_cur = '0; deb_prev = '0;
      stat_m = '0; ie_m = 1'b0; irq_m = 1'b0;
      smp = {};
      for (int i = 0; i < SS; i++) smp.push_back('0);
    end else begin
      raw_now = {user_key, dip_switch};
      and_all = '1; or_all = '0;
      foreach (smp[i]) begin
        and_all &= smp[i];
        or_all  |= smp[i];
      end
      nxt = (deb_cur | and_all) & or_all;
      if ((n_m % TP) == TP - 1) begin
        smp.push_front(~raw_d2);
        void'(smp.pop_back());
        ticks_m++;
      end
      set[0] = |(deb_cur[63:0] ^ deb_prev[63:0]);
      set[1] = |(deb_cur[71:64] & ~deb_prev[71:64]);
      clr = (we && addr == 3'd3) ? din[1:0] : 2'b00;
`ifdef SWITCH_IRQ_EN
      irq_m = ie_m & (|stat_m);
      if (we && addr == 3'd4) ie_m = din[0];
`endif
      stat_m = (stat_m & ~clr) | set;
      deb_prev = deb_cur;
      deb_cur = nxt;
      raw_d2 = raw_d1;
      raw_d1 = raw_now;
      n_m++;
    end
  end

  function automatic logic [31:0] exp_dout(input logic [2:0] a);
    case (a)
      3'd0:    return deb_cur[31:0];
      3'd1:    return deb_cur[63:32];
      3'd2:    return 32'(deb_cur[71:64]);
      3'd3:    return 32'(stat_m);
      3'd4:    return 32'(ie_m);
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a);
      #1;
      chk($sformatf("model_rd%0d", a), dout, exp_dout(3'(a)));
    end
    chk("model_irq", 32'(irq), 32'(irq_m));
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    check_all();
    addr = a; din = d; we = 1'b1;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk);
    addr = a;
    #1;
    chk(tag, dout, exp);
  endtask

  initial begin
    int first;
    int t0;
    bit done;
    logic [31:0] sw_lo_exp;

    // Scenario 1: reset, inputs idle-high
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 5; a++) rd_chk($sformatf("rst_rd%0d", a), 3'(a), 32'd0);
    @(negedge clk);
    chk("rst_irq", 32'(irq), 32'd0);
    run(4);

    // Scenario 2: four switches on, debounce latency bound
    @(negedge clk);
    dip_switch[3:0] = 4'h0;
    first = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      addr = 3'd0;
      #1;
      if (first == 0 && dout == 32'h0000_000F) first = c;
      check_all();
    end
    chk("sw_latency_ok", 32'((first > 0) && (first <= 51)), 32'd1);
    rd_chk("sw_lo", 3'd0, 32'h0000_000F);
    rd_chk("stat_sw", 3'd3, 32'h1);

    // Scenario 3: 20-cycle key glitch is rejected
    write(3'd3, 32'h3);
    run(2);
    user_key[0] = 1'b0;
    run(20);
    user_key[0] = 1'b1;
    run(60);
    rd_chk("glitch_key", 3'd2, 32'd0);
    rd_chk("glitch_stat", 3'd3, 32'd0);

    // Scenario 4: interrupt on key 5 press, W1C drops irq
    write(3'd4, 32'h1);
`ifdef SWITCH_IRQ_EN
    rd_chk("ctrl_ie", 3'd4, 32'h1);
`else
    rd_chk("ctrl_ie", 3'd4, 32'h0);
`endif
    user_key[5] = 1'b0;
    run(70);
    rd_chk("key5", 3'd2, 32'h20);
    rd_chk("stat_key", 3'd3, 32'h2);
    @(negedge clk);
`ifdef SWITCH_IRQ_EN
    chk("irq_set", 32'(irq), 32'd1);
`else
    chk("irq_set", 32'(irq), 32'd0);
`endif
    write(3'd3, 32'h2);
    run(2);
    chk("irq_clr", 32'(irq), 32'd0);
    rd_chk("stat_clr", 3'd3, 32'h0);
    user_key[5] = 1'b1;
    run(70);
    write(3'd4, 32'h0);
    write(3'd3, 32'h3);

    // Scenario 5: W1C coincides with a new SW_CHG set
    run(2);
    dip_switch[10] = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      check_all();
      if (deb_cur[63:0] != deb_prev[63:0]) begin
        addr = 3'd3; din = 32'h1; we = 1'b1;
        @(posedge clk);
        #1 we = 1'b0;
        done = 1'b1;
      end
    end
    chk("w1c_window_found", 32'(done), 32'd1);
    rd_chk("set_wins", 3'd3, 32'h1);
    write(3'd3, 32'h3);

    // Scenario 6: reset in the middle of an accept window
    run(2);
    dip_switch[20] = 1'b0;
    run(2);
    t0 = int'(ticks_m);
    for (int c = 0; c < 80 && int'(ticks_m) < t0 + 2; c++) run(1);
    chk("mid_window_reached", 32'(int'(ticks_m) - t0), 32'd2);
    run(3);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd_chk("rst_mid_sw", 3'd0, 32'd0);
    rd_chk("rst_mid_stat", 3'd3, 32'd0);
    run(10);
    rd_chk("rst_mid_stat_early", 3'd3, 32'd0);
    run(70);
    sw_lo_exp = ~dip_switch[31:0];
    rd_chk("redeb_sw", 3'd0, sw_lo_exp);
    rd_chk("redeb_stat", 3'd3, 32'h1);

    // Random input activity and bus writes against the model
    for (int it = 0; it < 60; it++) begin
      int idx;
      idx = int'($urandom_range(71, 0));
      if (idx < 64) dip_switch[idx] = ~dip_switch[idx];
      else user_key[idx - 64] = ~user_key[idx - 64];
      if ($urandom_range(3, 0) == 0) write(3'($urandom_range(7, 0)), $urandom);
      run(int'($urandom_range(60, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/switch_input.md
SWITCH_INPUT -- requirements
Module: switch_input

Interface
REQ-001 SHALL have parameter TICK_WIDTH, default 16; the sample tick period is 2^TICK_WIDTH clk cycles.
REQ-002 SHALL have parameter STABLE_SAMPLES, default 3; this many equal consecutive samples accept a new input value.
REQ-003 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port we  input  1  bus write strobe.
REQ-006 SHALL have port addr  input  3  register select.
REQ-007 SHALL have port din  input  32  bus write data.
REQ-008 SHALL have port dout  output  32  bus read data.
REQ-009 SHALL have port dip_switch  input  64  raw board switches, active-low, asynchronous.
REQ-010 SHALL have port user_key  input  8  raw push keys, active-low, asynchronous.
REQ-011 SHALL have port irq  output  1  interrupt request, level, active-high.

Function
REQ-012 SHALL pass every raw bit through a 2-flop synchronizer and then invert it, so that logic 1 means on or pressed.
REQ-013 SHALL run a TICK_WIDTH-bit free-running counter that raises a one-cycle tick when it wraps from all-ones to 0.
REQ-014 SHALL shift each synchronized bit into a per-bit STABLE_SAMPLES-deep sample history on each tick only.
REQ-015 SHALL update a debounced bit only when its whole history is uniform; otherwise the debounced bit holds its value (glitch rejection).
REQ-016 SHALL update a debounced bit at most 2 + STABLE_SAMPLES*2^TICK_WIDTH + 1 cycles after the raw input settles.
REQ-017 SHALL set sticky status bit0 (SW_CHG) in the cycle after any debounced switch bit differs from its previous value.
REQ-018 SHALL set sticky status bit1 (KEY_PRESS) on any debounced key 0->1 edge; a release does not set it.
REQ-019 SHALL implement the register map: 0 = switches[31:0], 1 = switches[63:32], 2 = {24'b0, keys}, 3 = {30'b0, status}, 4 = {31'b0, ctrl.ie}; any other address reads 0.
REQ-020 SHALL drive dout combinationally from addr with zero wait states.
REQ-021 SHALL handle a write to addr 3 as write-1-to-clear on the status bits.
REQ-022 SHALL let set win when a status set and a W1C clear of the same bit fall in the same cycle.
REQ-023 SHALL latch din[0] into ctrl.ie on a write to addr 4.
REQ-024 SHALL ignore writes to addrs 0-2 and 5-7.

Reset
REQ-025 SHALL on reset clear the tick counter, synchronizers, histories, debounced values, status and ctrl.ie to 0, so dout reads 0 and irq = 0.
REQ-026 SHALL not set status for inputs already asserted when reset deasserts until they have debounced, and SHALL then set SW_CHG/KEY_PRESS once.
REQ-027 SHALL, if reset is asserted mid-debounce, discard partial history with no status update.

Configuration
REQ-028 SHALL, with SWITCH_IRQ_EN defined, drive irq = ctrl.ie & (status[0] | status[1]) from a register, asserting one cycle after the status bit sets.
REQ-029 SHALL, without SWITCH_IRQ_EN, tie irq to 0, read ctrl as 0 and ignore writes to addr 4; status stays fully functional for polling.

Structure
REQ-030 SHALL place the address constants (ADDR_SW_LO=0, ADDR_SW_HI=1, ADDR_KEY=2, ADDR_STAT=3, ADDR_CTRL=4) and the status bit indices in a shared package, switch_input_pkg.
REQ-031 SHALL implement the synchronizer, history and accept logic for one bit in a sub-module, debounce_bit, instantiated 72 times through generate.

Verification
REQ-032 Benches SHALL use TICK_WIDTH=4 (tick every 16 cycles) and STABLE_SAMPLES=3.
REQ-033 Scenario 1: hold reset, then release with all raw inputs 1 -> reads of addrs 0-4 return 0 and irq = 0.
REQ-034 Scenario 2: dip_switch[3:0] = 4'b0000, held 80 cycles -> addr 0 reads 0x0000000F within 51 cycles of settling, and status reads 0x1.
REQ-035 Scenario 3: glitch user_key[0] low for 20 cycles, then high -> addr 2 stays 0 and status bit1 stays 0.
REQ-036 Scenario 4: with SWITCH_IRQ_EN, write ctrl 1, press key 5 -> addr 2 reads 0x20, irq = 1; write 0x2 to addr 3 -> irq = 0 next cycle.
REQ-037 Scenario 5: W1C of bit0 in the same cycle a new switch change sets bit0 -> bit0 remains 1.
REQ-038 Scenario 6: assert reset halfway through a 3-sample accept window -> after release, debounced values are 0 and no status is set until a full re-debounce completes.
